// File: rtl/seg7_mux_bcd.sv
// Binary-to-BCD converter (sequential double-dabble) driving a multiplexed 7-segment display.
// Define SEG7_MUX_BCD_LZB_EN to blank the leading zeros.
module seg7_mux_bcd #(
   parameter int NUM_DIGITS     = 4,
   parameter int BIN_W          = 14,
   parameter int REFRESH_CYCLES = 100000
) (
   input  logic                  clk_100MHz,
   input  logic                  reset_n,
   input  logic                  load,
   input  logic [BIN_W-1:0]      value,
   output logic                  busy,
   output logic                  overflow,
   output logic [0:6]            seg,
   output logic [NUM_DIGITS-1:0] digit
);

   localparam int BCD_W = 4 * NUM_DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam int TMR_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
   localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [63:0] MAX_VAL = 64'(10 ** NUM_DIGITS) - 64'd1;
   localparam logic [BCD_W-1:0] ALL_NINES = {NUM_DIGITS{4'd9}};

   typedef enum logic {S_IDLE, S_CONV} state_t;

   state_t             state_reg, state_next;
   logic [BIN_W-1:0]   bin_reg, bin_next;
   logic [BCD_W-1:0]   bcd_reg, bcd_next;
   logic [BCD_W-1:0]   bcd_adj, bcd_shift;
   logic [BCD_W-1:0]   disp_reg, disp_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic               ovf_pend_reg, ovf_pend_next;
   logic               overflow_reg, overflow_next;
   logic [TMR_W-1:0]   tmr_reg;
   logic [SEL_W-1:0]   sel_reg;
   logic [NUM_DIGITS-1:0] lzb;
   logic [3:0]         cur_bcd;
   logic               cur_blank;

   // Add-3 correction on every BCD nibble, then shift the next binary bit in.
   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
         assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                     bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
      end
   endgenerate

   assign bcd_shift = {bcd_adj[BCD_W-2:0], bin_reg[BIN_W-1]};

   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= S_IDLE;
         bin_reg      <= '0;
         bcd_reg      <= '0;
         cnt_reg      <= '0;
         ovf_pend_reg <= 1'b0;
         disp_reg     <= '0;
         overflow_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         bin_reg      <= bin_next;
         bcd_reg      <= bcd_next;
         cnt_reg      <= cnt_next;
         ovf_pend_reg <= ovf_pend_next;
         disp_reg     <= disp_next;
         overflow_reg <= overflow_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      bin_next      = bin_reg;
      bcd_next      = bcd_reg;
      cnt_next      = cnt_reg;
      ovf_pend_next = ovf_pend_reg;
      disp_next     = disp_reg;
      overflow_next = overflow_reg;
      if (state_reg == S_IDLE) begin
         if (load) begin
            state_next    = S_CONV;
            bin_next      = value;
            bcd_next      = '0;
            cnt_next      = '0;
            ovf_pend_next = (64'(value) > MAX_VAL);
         end
      end else begin
         bin_next = bin_reg << 1;
         bcd_next = bcd_shift;
         cnt_next = cnt_reg + CNT_W'(1);
         // Last bit: the display and overflow flag change together as busy drops.
         if (cnt_reg == CNT_W'(BIN_W - 1)) begin
            state_next    = S_IDLE;
            overflow_next = ovf_pend_reg;
            disp_next     = ovf_pend_reg ? ALL_NINES : bcd_shift;
         end
      end
   end

   assign busy     = (state_reg == S_CONV);
   assign overflow = overflow_reg;

   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         tmr_reg <= '0;
         sel_reg <= '0;
      end else if (tmr_reg == TMR_W'(REFRESH_CYCLES - 1)) begin
         tmr_reg <= '0;
         sel_reg <= (sel_reg == SEL_W'(NUM_DIGITS - 1)) ? '0 : sel_reg + SEL_W'(1);
      end else begin
         tmr_reg <= tmr_reg + TMR_W'(1);
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dig
         assign digit[gi] = (sel_reg != SEL_W'(gi));
      end
   endgenerate

`ifdef SEG7_MUX_BCD_LZB_EN
   logic zero_run;

   // A digit is blanked when it and every digit above it are zero.
   always_comb begin
      lzb      = '0;
      zero_run = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         zero_run = zero_run && (disp_reg[4*i +: 4] == 4'd0);
         lzb[i]   = zero_run && !overflow_reg;
      end
   end
`else
   assign lzb = '0;
`endif

   // Digit code and blanking are taken from the same select as the enables.
   always_comb begin
      cur_bcd   = '0;
      cur_blank = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (sel_reg == SEL_W'(i)) begin
            cur_bcd   = disp_reg[4*i +: 4];
            cur_blank = lzb[i];
         end
      end
   end

   function automatic logic [6:0] seg_decode(input logic [3:0] code);
      case (code)
         4'd0:    return 7'b0000001;
         4'd1:    return 7'b1001111;
         4'd2:    return 7'b0010010;
         4'd3:    return 7'b0000110;
         4'd4:    return 7'b1001100;
         4'd5:    return 7'b0100100;
         4'd6:    return 7'b0100000;
         4'd7:    return 7'b0001111;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0000100;
         default: return 7'b1111111;
      endcase
   endfunction

   assign seg = cur_blank ? 7'b1111111 : seg_decode(cur_bcd);

endmodule

// File: doc/seg7_mux_bcd.md
SEG7_MUX_BCD -- requirements
Module: seg7_mux_bcd

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of display digits (legal range 1..8).
REQ-002 SHALL have parameter BIN_W, default 14, width of the binary input value.
REQ-003 SHALL have parameter REFRESH_CYCLES, default 100000, clock cycles each digit is held active.
REQ-004 SHALL have port clk_100MHz, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port load, input, 1, request to convert and display value.
REQ-007 SHALL have port value, input, BIN_W, unsigned binary number to display.
REQ-008 SHALL have port busy, output, 1, high while a conversion is in progress.
REQ-009 SHALL have port overflow, output, 1, high when the last accepted value exceeded 10^NUM_DIGITS-1.
REQ-010 SHALL have port seg, output, 7, indexed [0:6] = segments a..g, active-low.
REQ-011 SHALL have port digit, output, NUM_DIGITS, active-low digit enables; bit 0 = ones digit.

Function
REQ-012 SHALL accept load only when busy is low; load while busy is ignored with no effect.
REQ-013 SHALL, on an accepted load, capture value and assert busy on the next edge.
REQ-014 SHALL convert with a sequential shift-add-3 (double-dabble) engine, one bit per cycle, busy high for exactly BIN_W cycles.
REQ-015 SHALL update the displayed digit register atomically on the edge busy falls; the old value is shown until then.
REQ-016 SHALL, if the captured value > 10^NUM_DIGITS-1, display all digits as 9 and set overflow; otherwise clear overflow. Either update happens on the busy-fall edge.
REQ-017 SHALL run a refresh timer counting 0..REFRESH_CYCLES-1 continuously, independent of busy.
REQ-018 SHALL advance the digit select on the timer terminal count, wrapping from NUM_DIGITS-1 to 0, including non-power-of-two NUM_DIGITS.
REQ-019 SHALL drive exactly one digit bit low at all times: the selected digit.
REQ-020 SHALL decode BCD to seg as: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
REQ-021 SHALL drive seg=1111111 (blank) for any BCD code 10..15.
REQ-022 SHALL make seg and digit consistent in the same cycle, with no cycle where seg shows a neighbouring digit's pattern.
REQ-023 SHALL, when NUM_DIGITS=1, hold digit=0 permanently.

Reset
REQ-024 SHALL, while reset_n is low, force: displayed digits all 0, refresh timer 0, digit select 0, busy 0, overflow 0, conversion state idle.
REQ-025 SHALL therefore output digit = all ones except bit 0 low, and seg=0000001 during reset.
REQ-026 SHALL abort any in-progress conversion on reset; the partial result is discarded.

Configuration
REQ-027 SHALL provide macro SEG7_MUX_BCD_LZB_EN for leading-zero blanking.
REQ-028 SHALL, with SEG7_MUX_BCD_LZB_EN defined, blank (seg=1111111) every digit above the most significant non-zero digit. Digit 0 is never blanked. Overflow display is never blanked.
REQ-029 SHALL, without SEG7_MUX_BCD_LZB_EN, display leading zeros as 0.

Verification (bench uses REFRESH_CYCLES=4, NUM_DIGITS=4, BIN_W=14 unless noted)
REQ-030 SHALL cover: reset, then scan 16 cycles -> digit sequence 1110,1101,1011,0111 each held 4 cycles; seg=0000001 throughout.
REQ-031 SHALL cover: load value=1234 -> busy high exactly 14 cycles; then digits 0..3 show 4,3,2,1 (1001100,0000110,0010010,1001111); overflow=0.
REQ-032 SHALL cover: load value=12000 -> after busy falls, all digits show 0000100 and overflow=1; then load 5 -> overflow=0.
REQ-033 SHALL cover: load 42, then pulse load with 99 at busy cycle 3 -> second load ignored; display shows 0042.
REQ-034 SHALL cover: assert reset_n low at busy cycle 7 of a load of 9999 -> busy=0 immediately, display 0000 after release, next load accepted normally.
REQ-035 SHALL cover: with SEG7_MUX_BCD_LZB_EN, NUM_DIGITS=3, REFRESH_CYCLES=3, load 7 -> digits 1 and 2 show 1111111, digit 0 shows 0001111; load 0 -> digit 0 shows 0000001.
